// File: rtl/spi_pkg.sv
// spi_pkg: state encoding, default frame width and config-word field offsets
// shared by spi_fifo_ctrl and its FIFOs.
package spi_pkg;
  localparam int SPI_DW = 8;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_XFER    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;
  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    LOAD    = ST_LOAD,
    XFER    = ST_XFER,
    CAPTURE = ST_CAPTURE
  } state_e;
  localparam int CFG_FW         = 8;
  localparam int CFG_BAUD_LSB   = 0;
  localparam int CFG_STATUS_LSB = 8;
  localparam int CFG_C2_LSB     = 16;
  localparam int CFG_C1_LSB     = 24;
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock FIFO; push while full and pop while empty are ignored.
module spi_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/spi_fifo_ctrl.sv
// spi_fifo_ctrl: TX/RX FIFOs around an spi_module, one frame in flight at a time.
// Optional XFER watchdog enabled by `define SPI_XFER_TIMEOUT_EN.
module spi_fifo_ctrl
  import spi_pkg::*;
#(
  parameter int DW          = SPI_DW,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic          i_sys_clk,
  input  logic          i_sys_rst,
  input  logic          i_wr_valid,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_wr_ready,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_rd_ready,
  input  logic [31:0]   i_cfg,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_rx_ovf,
  output logic          o_timeout,
  output logic [DW-1:0] o_spi_data,
  output logic [31:0]   o_spi_cfg,
  output logic          o_trans_en,
  input  logic          i_spi_irq,
  input  logic [DW-1:0] i_spi_data
);
  state_e        state, state_nx;
  logic          irq_q, irq_edge, tmo_hit, more;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [DW-1:0] tx_head;
  spi_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
    .clk(i_sys_clk), .rst_n(i_sys_rst),
    .push(i_wr_valid), .push_data(i_wr_data),
    .pop(state == LOAD), .head(tx_head),
    .full(tx_full), .empty(tx_empty)
  );
  spi_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
    .clk(i_sys_clk), .rst_n(i_sys_rst),
    .push(state == CAPTURE), .push_data(i_spi_data),
    .pop(i_rd_ready), .head(o_rd_data),
    .full(rx_full), .empty(rx_empty)
  );
  assign o_wr_ready = !tx_full;
  assign o_rd_valid = !rx_empty;
  assign o_busy     = state != IDLE;
  assign o_trans_en = state == LOAD;
  assign irq_edge   = i_spi_irq && !irq_q;
  assign more       = i_start && !tx_empty;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = more ? LOAD : IDLE;
      LOAD:    state_nx = XFER;
      XFER:    state_nx = irq_edge ? CAPTURE : (tmo_hit ? IDLE : XFER);
      CAPTURE: state_nx = more ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state      <= IDLE;
      irq_q      <= 1'b0;
      o_spi_data <= '0;
      o_spi_cfg  <= '0;
      o_rx_ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      irq_q <= i_spi_irq;
      if (state == IDLE)
        o_spi_cfg <= {i_cfg[CFG_C1_LSB +: CFG_FW], i_cfg[CFG_C2_LSB +: CFG_FW],
                      i_cfg[CFG_STATUS_LSB +: CFG_FW], i_cfg[CFG_BAUD_LSB +: CFG_FW]};
      if (state == LOAD) o_spi_data <= tx_head;
      if (state == CAPTURE && rx_full) o_rx_ovf <= 1'b1;
    end
  end
`ifdef SPI_XFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  // counter reads k-1 in the k-th XFER cycle, so the flag lands at the end of cycle TIMEOUT_CYC
  assign tmo_hit = !irq_edge && tmo_cnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      tmo_cnt   <= '0;
      o_timeout <= 1'b0;
    end else begin
      tmo_cnt <= (state == XFER) ? tmo_cnt + 1'b1 : '0;
      if (state == XFER && tmo_hit) o_timeout <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign o_timeout = TIMEOUT_CYC < 0;
`endif
endmodule
